// File: rtl/lifo_stack.sv
// Self-managing LIFO stack with internal stack pointer, full/empty/count status and replace-top.
// Optional sticky overflow/underflow flags are built when STACK_ERR_EN is defined.
module lifo_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   count,
    output logic [1:0]       err
);

    localparam int          ENTRIES = 1 << DEPTH;
    localparam logic [DEPTH:0] SP_ONE  = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH:0] SP_FULL = {1'b1, {DEPTH{1'b0}}};

    logic [WIDTH-1:0] store [ENTRIES];
    logic [DEPTH:0]   sp;
    logic [DEPTH:0]   sp_next;
    logic [DEPTH-1:0] top_idx;
    logic [DEPTH-1:0] waddr;
    logic             we;
    logic             overflow;
    logic             underflow;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_FULL);
    assign count   = sp;
    // Low bits minus one wraps correctly when full (sp = 2**DEPTH -> index 2**DEPTH-1).
    assign top_idx = sp[DEPTH-1:0] - {{(DEPTH-1){1'b0}}, 1'b1};
    assign top     = empty ? '0 : store[top_idx];

    always_comb begin
        sp_next   = sp;
        we        = 1'b0;
        waddr     = sp[DEPTH-1:0];
        overflow  = 1'b0;
        underflow = 1'b0;
        if (!clear) begin
            if (push && !pop) begin
                if (full) begin
                    overflow = 1'b1;
                end else begin
                    we      = 1'b1;
                    sp_next = sp + SP_ONE;
                end
            end else if (pop && !push) begin
                if (empty) underflow = 1'b1;
                else       sp_next   = sp - SP_ONE;
            end else if (push && pop) begin
                we = 1'b1;
                if (empty) begin
                    // Replace on an empty stack degrades to a plain push.
                    underflow = 1'b1;
                    sp_next   = sp + SP_ONE;
                end else begin
                    waddr = top_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)    sp <= '0;
        else if (clear) sp <= '0;
        else            sp <= sp_next;
    end

    always_ff @(posedge clk) begin
        if (we) store[waddr] <= din;
    end

`ifdef STACK_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)    err_q <= 2'b00;
        else if (clear) err_q <= 2'b00;
        else            err_q <= err_q | {underflow, overflow};
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = overflow ^ underflow;
    assign err        = 2'b00;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Randomized bench for lifo_stack against a queue-based reference stack model.
// Define STACK_ERR_EN for both bench and RTL to check the sticky error flags.
module tb_lifo_stack;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int CAP   = 1 << DEPTH;

    logic             clk;
    logic             resetq;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic [DEPTH:0]   count;
    logic [1:0]       err;

    logic [WIDTH-1:0] exp_q[$];
    logic [1:0]       exp_err;
    int               tests_run;
    int               tests_failed;

    lifo_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .resetq(resetq),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .top   (top),
        .empty (empty),
        .full  (full),
        .count (count),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_err = 2'b00;
    endtask

    // Reference stack behaviour for one clock edge.
    task automatic model_step(input logic c, input logic p, input logic q, input logic [WIDTH-1:0] d);
        if (c) begin
            model_reset();
        end else if (p && !q) begin
            if (exp_q.size() < CAP) exp_q.push_back(d);
            else                    exp_err[0] = 1'b1;
        end else if (q && !p) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            else                  exp_err[1] = 1'b1;
        end else if (p && q) begin
            if (exp_q.size() > 0) begin
                exp_q[exp_q.size()-1] = d;
            end else begin
                exp_q.push_back(d);
                exp_err[1] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] exp_top;
        logic [1:0]       want_err;
        exp_top = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
`ifdef STACK_ERR_EN
        want_err = exp_err;
`else
        want_err = 2'b00;
`endif
        check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(exp_q.size() == CAP));
        check({tag, "_top"},   32'(top),   32'(exp_top));
        check({tag, "_err"},   32'(err),   32'(want_err));
    endtask

    // Drive one cycle's operation, let the edge happen, then compare 1 ns later.
    task automatic do_cycle(input string tag, input logic c, input logic p, input logic q,
                            input logic [WIDTH-1:0] d);
        clear = c;
        push  = p;
        pop   = q;
        din   = d;
        @(posedge clk);
        model_step(c, p, q, d);
        #1;
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        int               r;
        int               push_pct;
        tests_run    = 0;
        tests_failed = 0;
        resetq = 1'b0;
        clear  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        din    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        resetq = 1'b1;

        // LIFO order
        do_cycle("lifo_push", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0011));
        do_cycle("lifo_push", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0022));
        do_cycle("lifo_push", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0033));
        check("lifo_top3", 32'(top), 32'(WIDTH'(16'h0033)));
        for (int i = 0; i < 3; i++) do_cycle("lifo_pop", 1'b0, 1'b0, 1'b1, '0);
        check("lifo_empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a push
        do_cycle("pre_rst", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0044));
        push = 1'b1;
        din  = WIDTH'(16'h0055);
        #2;
        resetq = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        push = 1'b0;
        @(negedge clk);
        check_outputs("rst_hold");
        resetq = 1'b1;

        // Fill to full, then overflow
        for (int i = 0; i < CAP; i++) do_cycle("fill", 1'b0, 1'b1, 1'b0, WIDTH'(i * 7 + 1));
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'(CAP));
        do_cycle("overflow", 1'b0, 1'b1, 1'b0, WIDTH'(16'hBEEF));
        do_cycle("replace_full", 1'b0, 1'b1, 1'b1, WIDTH'(16'h0077));

        // Drain to 5 entries, then clear with push asserted
        for (int i = 0; i < CAP - 5; i++) do_cycle("drain", 1'b0, 1'b0, 1'b1, '0);
        do_cycle("clear", 1'b1, 1'b1, 1'b0, WIDTH'(16'h1234));
        check("clear_empty", 32'(empty), 32'd1);

        // Underflow, then push&pop on empty acts as push
        do_cycle("underflow", 1'b0, 1'b0, 1'b1, '0);
        do_cycle("pp_empty", 1'b0, 1'b1, 1'b1, WIDTH'(16'h0005));
        do_cycle("clear2", 1'b1, 1'b0, 1'b0, '0);

        // Replace top
        do_cycle("rep_push", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0011));
        do_cycle("rep_push", 1'b0, 1'b1, 1'b0, WIDTH'(16'h0022));
        do_cycle("replace", 1'b0, 1'b1, 1'b1, WIDTH'(16'h0099));
        check("replace_top", 32'(top), 32'(WIDTH'(16'h0099)));
        do_cycle("rep_pop", 1'b0, 1'b0, 1'b1, '0);
        check("rep_pop_top", 32'(top), 32'(WIDTH'(16'h0011)));

        // Random phases alternate between filling and draining bias
        push_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) push_pct = (push_pct == 70) ? 30 : 70;
            r = $urandom_range(0, 99);
            v = WIDTH'($urandom);
            if (r < 2)
                do_cycle("rnd", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v);
            else if (r < 12)
                do_cycle("rnd", 1'b0, 1'b1, 1'b1, v);
            else if (r < 12 + push_pct * 85 / 100)
                do_cycle("rnd", 1'b0, 1'b1, 1'b0, v);
            else if (r < 97)
                do_cycle("rnd", 1'b0, 1'b0, 1'b1, v);
            else
                do_cycle("rnd", 1'b0, 1'b0, 1'b0, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
